// File: rtl/dmem_pkg.sv
// Shared types and address-decode helpers for the data-memory store logger.
// Defines the 80-bit log entry layout {addr, data, stamp}.
package dmem_pkg;

    localparam int LOG_ENTRY_W = 80;
    localparam int STAMP_LSB   = 0;
    localparam int DATA_LSB    = 16;
    localparam int ADDR_LSB    = 48;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] stamp;
    } log_entry_t;

    function automatic logic aligned(input logic [31:0] a);
        return a[1:0] == 2'b00;
    endfunction

    // Widened compare so large word counts cannot overflow.
    function automatic logic in_range(input logic [31:0] a,
                                      input int unsigned words);
        logic [33:0] lim;
        lim = 34'(words) << 2;
        return {2'b00, a} < lim;
    endfunction

    function automatic logic in_window(input logic [31:0] a,
                                       input int unsigned base,
                                       input int unsigned span);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = 33'(base);
        hi = 33'(base) + 33'(span);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through head output.
// Ports: clk, reset, push/din, pop, full, empty, count, head (0 when empty).
module sync_fifo
    import dmem_pkg::*;
#(
    parameter int WIDTH = LOG_ENTRY_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO only lands when the head leaves this cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dmem_store_logger.sv
// Data RAM for the single-cycle core that also logs window stores to a FIFO.
// Ports: core bus (MemWrite/DataAdr/WriteData/ReadData), log valid/ready drain, sticky flags.
module dmem_store_logger
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned LOG_BASE  = 100,
    parameter int unsigned LOG_SPAN  = 32,
    parameter int unsigned LOG_DEPTH = 8,
    parameter int unsigned HALT_ADDR = 252,
    parameter string       INIT_FILE = ""
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [31:0]                  DataAdr,
    input  logic [31:0]                  WriteData,
    output logic [31:0]                  ReadData,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data,
    output logic [15:0]                  log_stamp,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         overflow,
    output logic                         misalign,
    output logic                         halted
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   ram_q [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          adr_ok, adr_al, st, ram_we;
    logic          push, pop, fifo_full, fifo_empty;
    log_entry_t    entry_in, entry_head;

    logic [15:0] stamp_q, stamp_d;
    logic        overflow_q, overflow_d;
    logic        misalign_q, misalign_d;
    logic        halted_q, halted_d;

    assign idx    = DataAdr[AW+1:2];
    assign adr_ok = in_range(DataAdr, MEM_WORDS);
    assign adr_al = aligned(DataAdr);
    assign st     = MemWrite & ~reset;
    assign ram_we = st & adr_al & adr_ok;

    assign ReadData = adr_ok ? ram_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[idx] <= WriteData;
    end

    assign push     = st & adr_al & in_window(DataAdr, LOG_BASE, LOG_SPAN);
    assign pop      = log_ready & ~fifo_empty;
    assign entry_in = '{addr: DataAdr, data: WriteData, stamp: stamp_q};

    sync_fifo #(
        .WIDTH (LOG_ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (entry_in),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (log_count),
        .head  (entry_head)
    );

    assign log_valid = ~fifo_empty;
    assign log_addr  = entry_head.addr;
    assign log_data  = entry_head.data;
    assign log_stamp = entry_head.stamp;

    always_comb begin
        stamp_d    = stamp_q + 16'd1;
        overflow_d = overflow_q | (push & fifo_full & ~pop);
        misalign_d = misalign_q | (st & ~adr_al);
        halted_d   = halted_q | (st & adr_al & (DataAdr == 32'(HALT_ADDR)));
        if (reset) begin
            stamp_d    = '0;
            overflow_d = 1'b0;
            misalign_d = 1'b0;
            halted_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        stamp_q    <= stamp_d;
        overflow_q <= overflow_d;
        misalign_q <= misalign_d;
        halted_q   <= halted_d;
    end

    assign overflow = overflow_q;
    assign misalign = misalign_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_dmem_store_logger.sv
// Randomised and directed bench for dmem_store_logger against a queue-based model.
// Outputs sampled 1 time unit after the falling edge, before the next rising edge.
module tb_dmem_store_logger;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [15:0] log_stamp;
    logic [3:0]  log_count;
    logic        overflow;
    logic        misalign;
    logic        halted;

    always #5 clk = ~clk;

    dmem_store_logger dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_addr  (log_addr),
        .log_data  (log_data),
        .log_stamp (log_stamp),
        .log_count (log_count),
        .overflow  (overflow),
        .misalign  (misalign),
        .halted    (halted)
    );

    // Reference model state
    logic [79:0] mq[$];
    logic [31:0] mmem [int];
    bit          m_ovf, m_mis, m_halt;
    logic [15:0] m_stamp;
    bit          chk_en;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit we,
                              input logic [31:0] adr,
                              input logic [31:0] wd, input bit rdy);
        bit al, win, pop, push;
        if (rst) begin
            mq.delete();
            m_ovf   = 0;
            m_mis   = 0;
            m_halt  = 0;
            m_stamp = 0;
            return;
        end
        al   = (adr % 4) == 0;
        win  = (adr >= 32'd100) && (adr < 32'd132);
        pop  = rdy && (mq.size() != 0);
        push = we && al && win;
        if (we && al && adr < 32'd256) mmem[int'(adr / 4)] = wd;
        if (we && !al) m_mis = 1;
        if (we && al && adr == 32'd252) m_halt = 1;
        if (push && mq.size() == 8 && !pop) m_ovf = 1;
        if (pop) void'(mq.pop_front());
        if (push && mq.size() < 8) mq.push_back({adr, wd, m_stamp});
        m_stamp = m_stamp + 16'd1;
    endtask

    task automatic cyc(input bit rst, input bit we,
                       input logic [31:0] adr,
                       input logic [31:0] wd, input bit rdy);
        reset     = rst;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        log_ready = rdy;
        #1;
        if (chk_en) begin
            chk("log_valid", 80'(log_valid), 80'(mq.size() != 0));
            chk("log_count", 80'(log_count), 80'(mq.size()));
            chk("log_head", {log_addr, log_data, log_stamp},
                (mq.size() != 0) ? mq[0] : 80'd0);
            chk("overflow", 80'(overflow), 80'(m_ovf));
            chk("misalign", 80'(misalign), 80'(m_mis));
            chk("halted", 80'(halted), 80'(m_halt));
            if (adr >= 32'd256)
                chk("rdata_oor", 80'(ReadData), 80'd0);
            else if (mmem.exists(int'(adr / 4)))
                chk("rdata", 80'(ReadData), 80'(mmem[int'(adr / 4)]));
        end
        @(posedge clk);
        model_edge(rst, we, adr, wd, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 32'd100, 32'd0, rdy);
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        reset = 1; MemWrite = 0; DataAdr = 0; WriteData = 0; log_ready = 0;
        chk_en = 0;
        @(negedge clk);
        cyc(1, 0, 32'd0, 32'd0, 0);
        chk_en = 1;
        cyc(1, 0, 32'd0, 32'd0, 0);

        // 1: first logged store
        cyc(0, 1, 32'd100, 32'h0689_0000, 0);
        idle(0);
        // 2: outside window, then misaligned
        cyc(0, 1, 32'd96, 32'h1111_2222, 0);
        cyc(0, 1, 32'd101, 32'hDEAD_BEEF, 0);
        idle(0);
        cyc(0, 0, 32'd96, 32'd0, 1);
        idle(1);
        // 3: nine stores into an empty FIFO with no drain
        for (int i = 0; i < 9; i++)
            cyc(0, 1, 32'd100 + 32'(4 * (i % 8)), 32'hA000_0000 + 32'(i), 0);
        idle(0);
        for (int i = 0; i < 9; i++) idle(1);
        // 4: full FIFO, push and pop together
        cyc(1, 0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 32'd104 + 32'(4 * (i % 6)), 32'hB000_0000 + 32'(i), 0);
        cyc(0, 1, 32'd128, 32'hC0FF_EE00, 1);
        idle(0);
        for (int i = 0; i < 9; i++) idle(1);
        // 5: halt, then reset retains RAM
        cyc(0, 1, 32'd100, 32'h0689_0000, 1);
        cyc(0, 1, 32'd252, 32'h0000_0001, 1);
        idle(1);
        cyc(1, 0, 32'd100, 32'd0, 1);
        idle(1);
        // Empty FIFO with pop request and push together
        cyc(0, 1, 32'd112, 32'h5555_AAAA, 1);
        idle(0);
        // 6: same-cycle load/store, then stamp wrap
        cyc(0, 1, 32'd104, 32'h7777_0001, 1);
        cyc(0, 1, 32'd104, 32'h7777_0002, 1);
        idle(1);
        cyc(0, 1, 32'd108, 32'h8888_0000, 0);
        chk_en = 0;
        for (int i = 0; i < 65536; i++) idle(0);
        chk_en = 1;
        cyc(0, 1, 32'd112, 32'h8888_0001, 0);
        idle(1);
        idle(1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 9));
            unique case (k)
                0, 1, 2, 3: a = 32'd100 + 32'(4 * $urandom_range(0, 7));
                4:          a = 32'(4 * $urandom_range(0, 63));
                5:          a = 32'($urandom_range(0, 300));
                6:          a = 32'd252;
                7:          a = $urandom();
                default:    a = 32'd96 + 32'($urandom_range(0, 40));
            endcase
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
                a, $urandom(), $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
